// File: rtl/fre_measure.sv
// Equal-precision frequency meter: counts fx periods (nx) and clk cycles (ns)
// over a gate that opens and closes on synchronized fx rising edges.
module fre_measure #(
    parameter int GATE_CYCLES = 100,
    parameter int TIMEOUT     = 1000,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fx,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] nx,
    output logic [CNT_W-1:0] ns
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_COUNT = 3'd2,
        S_CLOSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    state_t           state_r, state_next_s;
    logic             fx_meta_r, fx_sync_r, fx_prev_r;
    logic             fx_rise_s;
    logic             abort_s;
    logic [CNT_W-1:0] ns_c_r, nx_c_r, wc_r;
    logic [CNT_W-1:0] ns_inc_s, nx_inc_s;
    logic             busy_r, done_r, timeout_r;
    logic [CNT_W-1:0] nx_r, ns_r;

    assign fx_rise_s = fx_sync_r & ~fx_prev_r;
    // Values the counters take at the end of this cycle; the closing edge
    // is itself counted, so results are taken from these.
    assign ns_inc_s  = sat_inc(ns_c_r);
    assign nx_inc_s  = sat_inc(nx_c_r);

    assign busy    = busy_r;
    assign done    = done_r;
    assign timeout = timeout_r;
    assign nx      = nx_r;
    assign ns      = ns_r;

    // fx synchronizer and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fx_meta_r <= 1'b0;
            fx_sync_r <= 1'b0;
            fx_prev_r <= 1'b0;
        end else begin
            fx_meta_r <= fx;
            fx_sync_r <= fx_meta_r;
            fx_prev_r <= fx_sync_r;
        end
    end

    // Next-state logic; fx_rise has priority over the wait timeout
    always_comb begin
        state_next_s = state_r;
        abort_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) state_next_s = S_ARM;
                else       state_next_s = S_IDLE;
            end
            S_ARM: begin
                if (fx_rise_s) begin
                    state_next_s = S_COUNT;
                end else if (wc_r == TO_LAST) begin
                    state_next_s = S_DONE;
                    abort_s      = 1'b1;
                end else begin
                    state_next_s = S_ARM;
                end
            end
            S_COUNT: begin
                if (ns_inc_s >= GATE_LAST) state_next_s = S_CLOSE;
                else                       state_next_s = S_COUNT;
            end
            S_CLOSE: begin
                if (fx_rise_s) begin
                    state_next_s = S_DONE;
                end else if (wc_r == TO_LAST) begin
                    state_next_s = S_DONE;
                    abort_s      = 1'b1;
                end else begin
                    state_next_s = S_CLOSE;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_IDLE;
        else        state_r <= state_next_s;
    end

    // Gate counters: ns_c/nx_c run inside the gate, wc bounds each fx wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ns_c_r <= CNT_ZERO;
            nx_c_r <= CNT_ZERO;
            wc_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        ns_c_r <= CNT_ZERO;
                        nx_c_r <= CNT_ZERO;
                        wc_r   <= CNT_ZERO;
                    end
                end
                S_ARM: begin
                    if (fx_rise_s) begin
                        ns_c_r <= CNT_ZERO;
                        nx_c_r <= CNT_ZERO;
                        wc_r   <= CNT_ZERO;
                    end else begin
                        wc_r <= sat_inc(wc_r);
                    end
                end
                S_COUNT: begin
                    ns_c_r <= ns_inc_s;
                    wc_r   <= CNT_ZERO;
                    if (fx_rise_s) nx_c_r <= nx_inc_s;
                end
                S_CLOSE: begin
                    ns_c_r <= ns_inc_s;
                    wc_r   <= sat_inc(wc_r);
                    if (fx_rise_s) nx_c_r <= nx_inc_s;
                end
                default: begin
                    wc_r <= wc_r;
                end
            endcase
        end
    end

    // Registered status and results, loaded on the transition into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            nx_r      <= CNT_ZERO;
            ns_r      <= CNT_ZERO;
        end else begin
            busy_r <= (state_next_s != S_IDLE);
            done_r <= (state_next_s == S_DONE);
            if (state_next_s == S_DONE) begin
                if (abort_s) begin
                    nx_r      <= CNT_ZERO;
                    ns_r      <= CNT_ZERO;
                    timeout_r <= 1'b1;
                end else begin
                    nx_r      <= nx_inc_s;
                    ns_r      <= ns_inc_s;
                    timeout_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fre_measure.sv
// Directed self-checking bench for fre_measure with a clk-locked fx generator.
module tb_fre_measure;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fx;
    logic        start;
    logic        busy, done, timeout;
    logic [31:0] nx, ns;

    int checks = 0;
    int errors = 0;

    // fx generator controls: period in clk cycles, optional rise limit
    int gen_on    = 0;
    int gen_per   = 10;
    int gen_limit = 0;
    int gen_rises = 0;
    int gen_phase = 0;

    always #5 clk = ~clk;

    fre_measure #(.GATE_CYCLES(100), .TIMEOUT(1000), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .fx(fx), .start(start),
        .busy(busy), .done(done), .timeout(timeout), .nx(nx), .ns(ns)
    );

    // fx changes 2 time units after posedge; high for per/2 cycles
    initial begin
        fx = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (gen_on != 0 && (gen_phase != 0 || gen_limit == 0 || gen_rises < gen_limit)) begin
                if (gen_phase == 0) begin
                    fx = 1'b1;
                    gen_rises++;
                end else if (gen_phase == gen_per / 2) begin
                    fx = 1'b0;
                end
                gen_phase = (gen_phase + 1) % gen_per;
            end else begin
                fx = 1'b0;
                gen_phase = 0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits at negedges for done; n=0 is the first negedge after the call
    task automatic wait_done(input int budget, output bit got, output int n, output int drops);
        got = 1'b0;
        n = 0;
        drops = 0;
        @(negedge clk);
        while (n < budget) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy !== 1'b1) drops++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic prep_fx(input int per, input int limit);
        gen_on = 0;
        repeat (6) @(negedge clk);
        gen_per = per;
        gen_limit = limit;
        gen_rises = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {busy, done, timeout});
        end
        checks++;
        if ({nx, ns} !== 64'd0) begin
            errors++;
            $display("FAIL reset_counts: got nx=%0d ns=%0d expected 0 0", nx, ns);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_gate_10();
        bit got; int n, drops;
        prep_fx(10, 0);
        pulse_start();
        gen_on = 1;
        wait_done(2000, got, n, drops);
        checks++;
        if (got !== 1'b1) begin errors++; $display("FAIL gate10_done: got %0d expected 1", got); end
        checks++;
        if (nx !== 32'd10 || ns !== 32'd100 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL gate10_result: got nx=%0d ns=%0d to=%b expected 10 100 0", nx, ns, timeout);
        end
        checks++;
        if (drops !== 0) begin errors++; $display("FAIL gate10_busy: got %0d low samples expected 0", drops); end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL gate10_after: got done,busy=%b expected 00", {done, busy});
        end
    endtask

    task automatic test_back_to_back();
        bit got; int n, drops;
        pulse_start();
        wait_done(2000, got, n, drops);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        wait_done(2000, got, n, drops);
        checks++;
        if (got !== 1'b1 || nx !== 32'd10 || ns !== 32'd100) begin
            errors++;
            $display("FAIL b2b_result: got done=%0d nx=%0d ns=%0d expected 1 10 100", got, nx, ns);
        end
    endtask

    task automatic test_arm_timeout();
        bit got; int n, drops;
        prep_fx(10, 0);
        pulse_start();
        wait_done(1500, got, n, drops);
        checks++;
        if (got !== 1'b1 || n !== 1000) begin
            errors++;
            $display("FAIL arm_to_latency: got done=%0d at %0d expected 1 at 1000", got, n);
        end
        checks++;
        if (timeout !== 1'b1 || nx !== 32'd0 || ns !== 32'd0) begin
            errors++;
            $display("FAIL arm_to_result: got to=%b nx=%0d ns=%0d expected 1 0 0", timeout, nx, ns);
        end
        checks++;
        if (drops !== 0) begin errors++; $display("FAIL arm_to_busy: got %0d low samples expected 0", drops); end
    endtask

    task automatic test_gate_7();
        bit got; int n, drops;
        prep_fx(7, 0);
        pulse_start();
        gen_on = 1;
        wait_done(2000, got, n, drops);
        checks++;
        if (got !== 1'b1 || nx !== 32'd15 || ns !== 32'd105 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL gate7_result: got done=%0d nx=%0d ns=%0d to=%b expected 1 15 105 0",
                     got, nx, ns, timeout);
        end
    endtask

    task automatic test_close_timeout();
        bit got; int n, drops;
        prep_fx(10, 10);
        pulse_start();
        gen_on = 1;
        wait_done(2500, got, n, drops);
        // gate opens at n=2, CLOSE entered 100 later, then 1000 wait cycles
        checks++;
        if (got !== 1'b1 || n !== 1102) begin
            errors++;
            $display("FAIL close_to_latency: got done=%0d at %0d expected 1 at 1102", got, n);
        end
        checks++;
        if (timeout !== 1'b1 || nx !== 32'd0 || ns !== 32'd0) begin
            errors++;
            $display("FAIL close_to_result: got to=%b nx=%0d ns=%0d expected 1 0 0", timeout, nx, ns);
        end
    endtask

    task automatic test_start_ignored();
        bit got; int n, drops;
        int extra;
        prep_fx(10, 0);
        pulse_start();
        gen_on = 1;
        repeat (50) @(negedge clk);
        pulse_start();
        wait_done(2000, got, n, drops);
        checks++;
        if (got !== 1'b1 || nx !== 32'd10 || ns !== 32'd100 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: got done=%0d nx=%0d ns=%0d to=%b expected 1 10 100 0",
                     got, nx, ns, timeout);
        end
        extra = 0;
        repeat (150) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL ignore_single: got %0d extra done expected 0", extra); end
    endtask

    task automatic test_reset_mid_count();
        bit got; int n, drops;
        int extra;
        pulse_start();
        repeat (40) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, timeout} !== 3'b000 || nx !== 32'd0 || ns !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got bdt=%b nx=%0d ns=%0d expected 000 0 0",
                     {busy, done, timeout}, nx, ns);
        end
        @(posedge clk);
        #4 rst_n = 1'b1;
        extra = 0;
        repeat (200) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL rst_mid_idle: got %0d active samples expected 0", extra); end
        prep_fx(10, 0);
        pulse_start();
        gen_on = 1;
        wait_done(2000, got, n, drops);
        checks++;
        if (got !== 1'b1 || nx !== 32'd10 || ns !== 32'd100 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_fresh: got done=%0d nx=%0d ns=%0d to=%b expected 1 10 100 0",
                     got, nx, ns, timeout);
        end
    endtask

    initial begin
        test_reset();
        test_gate_10();
        test_back_to_back();
        test_arm_timeout();
        test_gate_7();
        test_close_timeout();
        test_start_ignored();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fre_measure.md
Name: fre_measure

Overview:
- Equal-precision frequency measurement core. It is the consumer of the timebase that the clock divider produces: it counts an unknown input fx against the reference clock clk.
- The preset gate length comes from a clk-cycle count. The actual gate opens and closes on fx rising edges, so the fx count is always an integer number of periods.
- Outputs raw counts nx (fx periods) and ns (clk cycles). Downstream computes f_x = f_clk * nx / ns.

Parameters:
- GATE_CYCLES, 100, minimum preset gate length in clk cycles (use 100 for sim; on the board, f_clk for a 1 s gate).
- TIMEOUT, 1000, max clk cycles to wait for an fx rising edge in ARM or CLOSE before aborting.
- CNT_W, 32, width of nx/ns counters and outputs. Constraint: GATE_CYCLES + TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  reference clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- fx  in  1  unknown signal, asynchronous to clk.
- start  in  1  synchronous one-cycle request to begin a measurement.
- busy  out  1  high while a measurement is in progress (state != IDLE).
- done  out  1  one-cycle pulse when results are updated.
- timeout  out  1  status of the last measurement; 1 means aborted; valid from done, held until next done.
- nx  out  CNT_W  fx periods inside the actual gate; held until next done.
- ns  out  CNT_W  clk cycles inside the actual gate; held until next done.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; synchronizer flops, counters, busy, done, timeout, nx and ns all cleared to 0.
- fx input path:
  - Two-flop synchronizer, then a registered previous-value compare.
  - fx_rise = sync high and prev low; lasts one cycle per fx rising edge.
  - Pin-to-fx_rise latency is 2-3 clk. fx high/low times must each be >= 2 clk.
- IDLE:
  - On start=1, go to ARM next cycle and clear internal counters.
  - fx_rise in the start cycle is ignored.
- ARM:
  - Wait counter wc increments each cycle.
  - On fx_rise: open the actual gate, go to COUNT, set ns_c=0, nx_c=0, wc=0.
  - If wc reaches TIMEOUT-1 with no fx_rise: go to DONE with abort set.
- COUNT:
  - ns_c increments every cycle.
  - nx_c increments on each fx_rise.
  - When ns_c >= GATE_CYCLES-1 (preset gate expired), go to CLOSE.
  - fx_rise in that same cycle is counted, and the gate stays open.
- CLOSE:
  - ns_c keeps incrementing; wc counts from 0.
  - On the first fx_rise: nx_c increments, the gate closes, go to DONE.
  - If wc reaches TIMEOUT-1 first: go to DONE with abort set.
- Result definitions:
  - ns = number of clk cycles from the opening fx_rise cycle to the closing fx_rise cycle (difference of cycle indices).
  - nx = number of fx_rise events after the opening one, up to and including the closing one.
- DONE (one cycle):
  - Normal case: nx<=nx_c, ns<=ns_c, timeout<=0.
  - Abort case: nx<=0, ns<=0, timeout<=1.
  - done=1 this cycle only; next state IDLE.
  - busy falls in the cycle after DONE.
- start while busy=1 is ignored; no queuing.
- Counters saturate at all-ones as a safety net; this is unreachable under the parameter constraint.
- Back-to-back measurements: start may be asserted in the cycle IDLE is re-entered.

Test Plan:
- GATE_CYCLES=100, fx period 10 clk (5 high/5 low), pulse start -> one done pulse, nx=10, ns=100, timeout=0.
- GATE_CYCLES=100, fx period 7 clk -> nx=15, ns=105, timeout=0. ns/nx is exactly 7, with no ±1 error.
- fx held low, start pulse -> done exactly TIMEOUT cycles after ARM entry, timeout=1, nx=0, ns=0. busy high for the whole wait.
- fx period 10 clk, fx stopped low right after the preset gate expires -> timeout=1 after TIMEOUT cycles in CLOSE. The previous good nx/ns are overwritten with 0.
- start pulsed again mid-COUNT -> ignored; single done with the same values as the first scenario.
- rst_n low for 1 cycle mid-COUNT, asynchronous to clk -> outputs immediately 0, state IDLE, no done. A fresh start then gives nx=10, ns=100.
